// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use, redirect and memory-wait sequencing for a 5-stage core.
// state     | meaning
// RUN       | normal issue; arbitrates dmem stall > redirect > load-use > imem stall
// DMEM_WAIT | data access outstanding; whole pipe frozen, taken branches deferred
// IMEM_WAIT | fetch outstanding; NOPs fed into IF/ID, PC held unless a branch redirects
module hazard_ctrl_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             pc_write,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      IMEM_WAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              load_use;
   logic              dmem_stall;
   logic              redirect;
   logic              pc_write_c;
   logic              if_id_stall_c;
   logic              if_id_flush_c;
   logic              id_ex_bubble_c;
   logic              pipe_hold_c;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   assign dmem_stall = dmem_req && !dmem_ready;

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      pc_write_c     = 1'b1;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_bubble_c = 1'b0;
      pipe_hold_c    = 1'b0;
      redirect       = 1'b0;

      case (state_q)
         RUN: begin
            if (dmem_stall) begin
               pc_write_c    = 1'b0;
               if_id_stall_c = 1'b1;
               pipe_hold_c   = 1'b1;
               state_d       = DMEM_WAIT;
               if (branch_taken) pending_d = 1'b1;
            end else if (pending_q || branch_taken) begin
               // a deferred redirect takes precedence; a fresh branch_taken is ignored then
               if_id_flush_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
               redirect       = 1'b1;
               pending_d      = 1'b0;
            end else if (load_use) begin
               pc_write_c     = 1'b0;
               if_id_stall_c  = 1'b1;
               id_ex_bubble_c = 1'b1;
            end else if (!imem_ready) begin
               pc_write_c    = 1'b0;
               if_id_flush_c = 1'b1;
               state_d       = IMEM_WAIT;
            end
         end

         DMEM_WAIT: begin
            pc_write_c    = 1'b0;
            if_id_stall_c = 1'b1;
            pipe_hold_c   = 1'b1;
            if (branch_taken) pending_d = 1'b1;
            if (dmem_ready) state_d = RUN;
         end

         IMEM_WAIT: begin
            if_id_flush_c = 1'b1;
            if (branch_taken) begin
               id_ex_bubble_c = 1'b1;
               redirect       = 1'b1;
            end else begin
               pc_write_c = 1'b0;
               if (imem_ready) state_d = RUN;
            end
         end

         default: begin
            pc_write_c = 1'b0;
            state_d    = RUN;
            pending_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_c && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (redirect && (flush_cnt_q != CNT_MAX))    flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RUN;
         pending_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // while reset is held the pipe is kept quiescent: PC frozen and NOPs/bubbles injected
   assign pc_write     = reset_n ? pc_write_c     : 1'b0;
   assign if_id_stall  = reset_n ? if_id_stall_c  : 1'b1;
   assign if_id_flush  = reset_n ? if_id_flush_c  : 1'b1;
   assign id_ex_bubble = reset_n ? id_ex_bubble_c : 1'b1;
   assign pipe_hold    = reset_n ? pipe_hold_c    : 1'b0;

   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 ex_mem_read  in  1  instruction in EX is a load.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 branch_taken  in  1  EX has resolved a taken branch or jump; the PC mux already selects the target.
REQ-009 dmem_req  in  1  MEM stage has a data-memory access in flight.
REQ-010 dmem_ready  in  1  data memory completes this cycle.
REQ-011 imem_ready  in  1  instruction memory returns valid data this cycle.
REQ-012 pc_write  out  1  PC register load enable.
REQ-013 if_id_stall  out  1  drives the IF/ID register stall input (hold).
REQ-014 if_id_flush  out  1  IF/ID register loads a NOP (instruction 0x00000013).
REQ-015 id_ex_bubble  out  1  ID/EX register loads control-zero bubble.
REQ-016 pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB registers.
REQ-017 stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
REQ-018 flush_events  out  CNT_W  saturating count of applied redirects.

Function
REQ-019 FSM states RUN, DMEM_WAIT, IMEM_WAIT; outputs are combinational from state, pending_redirect and inputs.
REQ-020 load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-021 Priority in RUN: dmem stall > redirect > load_use > imem stall > normal.
REQ-022 RUN, dmem_req & !dmem_ready: pc_write=0, if_id_stall=1, pipe_hold=1; next state DMEM_WAIT.
REQ-023 RUN, branch_taken (no dmem stall): pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_stall=0; flush_events +1; state stays RUN.
REQ-024 RUN, load_use (no higher item): pc_write=0, if_id_stall=1, id_ex_bubble=1 for exactly one cycle; state stays RUN.
REQ-025 RUN, !imem_ready (no higher item): pc_write=0, if_id_flush=1; next state IMEM_WAIT.
REQ-026 RUN, none of the above: pc_write=1, all other control outputs 0.
REQ-027 DMEM_WAIT: pc_write=0, if_id_stall=1, pipe_hold=1 while dmem_ready=0; return to RUN in the cycle after dmem_ready=1.
REQ-028 branch_taken seen in the same cycle as a dmem stall, or during DMEM_WAIT, sets pending_redirect; branch_taken is ignored while pending_redirect=1.
REQ-029 First RUN cycle with pending_redirect=1: if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_events +1, pending_redirect cleared; load_use is ignored that cycle.
REQ-030 IMEM_WAIT: pc_write=0, if_id_flush=1 until imem_ready=1, then RUN next cycle.
REQ-031 IMEM_WAIT, branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1, flush_events +1; stay in IMEM_WAIT.
REQ-032 stall_cycles increments on every cycle with pc_write=0; both counters saturate at 2^CNT_W-1 with no wrap.
REQ-033 No combinational path from any output back to any input; outputs settle within the cycle.

Reset
REQ-034 reset_n=0 asynchronously forces state RUN, pending_redirect=0 and both counters to 0.
REQ-035 During reset: pc_write=0, if_id_stall=1, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
REQ-036 Reset deassertion mid-DMEM_WAIT resumes in RUN with no pending redirect; the first post-reset cycle follows REQ-021.

Verification
REQ-037 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_write=0, if_id_stall=1, id_ex_bubble=1; stall_cycles=1.
REQ-038 Same as REQ-037 but ex_rd=0 -> no stall; pc_write=1.
REQ-039 branch_taken=1 in RUN -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_events=1.
REQ-040 dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken pulsed in the 2nd cycle -> pipe_hold=1 for 4 cycles, then one flush cycle; flush_events=1, stall_cycles=4.
REQ-041 imem_ready=0 for 2 cycles -> if_id_flush=1 for 3 cycles, pc_write=0 for 3 cycles, then RUN.
REQ-042 reset_n low mid-DMEM_WAIT with pending_redirect=1 -> counters 0, state RUN, no flush after release.
